// File: rtl/uart_result_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_result_tx_if
//  Description : Result-word handshake plus serial/status outputs of the
//                UART result transmitter. The core side drives the word and
//                its valid flag. The transmitter returns ready, TXD, busy
//                and the word-done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_result_tx_if;
  logic [15:0] DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        TXD;
  logic        BUSY;
  logic        TX_DONE;

  modport master (
    output DATA_IN, DATA_VALID,
    input  DATA_READY, TXD, BUSY, TX_DONE
  );

  modport slave (
    input  DATA_IN, DATA_VALID,
    output DATA_READY, TXD, BUSY, TX_DONE
  );
endinterface
`default_nettype wire

// File: rtl/uart_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_result_tx
//  Description : Sends 16-bit result words as two back-to-back 8N1 UART
//                bytes, low byte first. A one-word holding register lets the
//                next word queue up while the current word is shifting out,
//                so consecutive words leave with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input wire              CLK,
  input wire              RESET,
  uart_result_tx_if.slave bus
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  // The done pulse is registered, so it is set one cycle before the last stop cycle.
  localparam logic [c_BAUD_W-1:0] c_BAUD_PRE  = c_BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [15:0]         r_hold;
  logic                r_hold_full;
  logic [15:0]         r_sh;
  logic                r_bidx;
  logic [2:0]          r_bit;
  logic [c_BAUD_W-1:0] r_baud;
  logic                r_txd;
  logic                r_tx_done;

  logic                w_accept;
  logic                w_baud_end;
  logic [7:0]          w_byte;

  // Accept only into an empty holding register. A transfer out of the holding
  // register needs it full, so an accept and a transfer never share an edge.
  assign w_accept   = bus.DATA_VALID & ~r_hold_full;
  assign w_baud_end = (r_baud == c_BAUD_LAST);
  assign w_byte     = r_bidx ? r_sh[15:8] : r_sh[7:0];

  // Holding register, bit timing and frame sequencing. TXD is registered and
  // updated on the edge that enters each bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_hold      <= 16'd0;
      r_hold_full <= 1'b0;
      r_sh        <= 16'd0;
      r_bidx      <= 1'b0;
      r_bit       <= 3'd0;
      r_baud      <= '0;
      r_txd       <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      if (w_accept) begin
        r_hold      <= bus.DATA_IN;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          if (r_hold_full) begin
            r_sh        <= r_hold;
            r_hold_full <= 1'b0;
            r_bidx      <= 1'b0;
            r_txd       <= 1'b0;
            r_state     <= S_START;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_txd   <= w_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_txd <= w_byte[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (r_bidx && (r_baud == c_BAUD_PRE)) begin
            r_tx_done <= 1'b1;
          end
          if (w_baud_end) begin
            r_baud <= '0;
            if (!r_bidx) begin
              // Low byte finished: the high byte starts with no gap.
              r_bidx  <= 1'b1;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else if (r_hold_full) begin
              // A queued word starts right after this stop bit.
              r_sh        <= r_hold;
              r_hold_full <= 1'b0;
              r_bidx      <= 1'b0;
              r_txd       <= 1'b0;
              r_state     <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.DATA_READY = ~r_hold_full;
  assign bus.TXD        = r_txd;
  assign bus.BUSY       = (r_state != S_IDLE) | r_hold_full;
  assign bus.TX_DONE    = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_result_tx
//  Description : Self-checking bench for uart_result_tx. Two instances are
//                used, with 4 and 87 clocks per bit. A UART decoder on the fast
//                instance checks the received words against a scoreboard.
//                Per-cycle waveform checks cover bit timing, gaps and
//                TX_DONE placement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_result_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_result_tx_if u4 ();
  uart_result_tx_if u87 ();

  uart_result_tx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (u4)
  );

  uart_result_tx #(.CLKS_PER_BIT(87)) dut87 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (u87)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_words[4];

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
    int          exp_wait;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // UART receiver on the 4-clock instance, sampling on the falling edge.
  int          m_k;
  logic [9:0]  m_val;
  bit          m_st = 1'b0;
  bit          m_ok;
  bit          m_got_lo = 1'b0;
  logic [7:0]  m_lo;
  int          n_words = 0;
  logic [15:0] m_word;
  logic [15:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_st     = 1'b0;
      m_got_lo = 1'b0;
    end else if (!m_st) begin
      if (u4.TXD == 1'b0) begin
        m_st     = 1'b1;
        m_k      = 1;
        m_val    = 10'd0;
        m_ok     = 1'b1;
      end
    end else begin
      if ((m_k % 4) == 0) m_val[m_k / 4] = u4.TXD;
      else if (u4.TXD !== m_val[m_k / 4]) m_ok = 1'b0;
      m_k++;
      if (m_k == 40) begin
        m_st = 1'b0;
        check("uart_byte_frame", {m_ok, m_val[9]}, 2'b11);
        if (!m_got_lo) begin
          m_lo     = m_val[8:1];
          m_got_lo = 1'b1;
        end else begin
          m_got_lo = 1'b0;
          m_word   = {m_val[8:1], m_lo};
          n_words++;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got %0h expected nothing", m_word);
          end else begin
            m_exp = sb.pop_front();
            check("sb_word", m_word, m_exp);
          end
        end
      end
    end
  end

  // Per-cycle reference waveform for n words of exp_words. Starts on the
  // edge after the accept edge, then checks one idle cycle after the last word.
  task automatic watch(input int c, input int sel, input int n);
    int bad_tx   = 0;
    int bad_done = 0;
    int bad_busy = 0;
    int fl       = 20 * c;
    for (int i = 0; i < n * fl; i++) begin
      logic [15:0] w;
      int          j;
      int          pos;
      logic        e;
      @(posedge clk); #1;
      w   = exp_words[i / fl];
      j   = (i % fl) / c;
      pos = j % 10;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = w[(j / 10) * 8 + pos - 1];
      if ((sel ? u87.TXD : u4.TXD) !== e) bad_tx++;
      if ((sel ? u87.TX_DONE : u4.TX_DONE) !== ((i % fl) == fl - 1)) bad_done++;
      if ((sel ? u87.BUSY : u4.BUSY) !== 1'b1) bad_busy++;
    end
    check("txd_wave_errs", bad_tx, 0);
    check("tx_done_errs", bad_done, 0);
    check("busy_frame_errs", bad_busy, 0);
    @(posedge clk); #1;
    check("idle_txd", sel ? u87.TXD : u4.TXD, 1'b1);
    check("idle_busy", sel ? u87.BUSY : u4.BUSY, 1'b0);
  endtask

  task automatic send_one(input logic [15:0] w, input int c, input int sel);
    @(negedge clk);
    if (sel) begin u87.DATA_IN = w; u87.DATA_VALID = 1'b1; end
    else     begin u4.DATA_IN  = w; u4.DATA_VALID  = 1'b1; end
    @(posedge clk); #1;
    check("accept_ready_low", sel ? u87.DATA_READY : u4.DATA_READY, 1'b0);
    check("txd_high_at_accept", sel ? u87.TXD : u4.TXD, 1'b1);
    if (sel) u87.DATA_VALID = 1'b0;
    else begin u4.DATA_VALID = 1'b0; sb.push_back(w); end
    exp_words[0] = w;
    watch(c, sel, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    tbl[0] = '{16'h5AF0, 8'hF0, 8'h5A, 0};
    tbl[1] = '{16'h0F0F, 8'h0F, 8'h0F, 1};
    tbl[2] = '{16'h1234, 8'h34, 8'h12, 79};
    tbl[3] = '{16'h8001, 8'h01, 8'h80, 79};

    u4.DATA_IN = 16'd0;  u4.DATA_VALID = 1'b0;
    u87.DATA_IN = 16'd0; u87.DATA_VALID = 1'b0;

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_txd", u4.TXD, 1'b1);
    check("rst_ready", u4.DATA_READY, 1'b1);
    check("rst_busy", u4.BUSY, 1'b0);
    check("rst_done", u4.TX_DONE, 1'b0);
    cnt = 0;
    repeat (50) begin @(posedge clk); #1; if (u4.TXD !== 1'b1) cnt++; end
    check("idle_50_txd_low_cycles", cnt, 0);

    // Single word, latency and TX_DONE placement
    send_one(16'hA53C, 4, 0);

    // Back-to-back with valid held high
    @(negedge clk); u4.DATA_IN = 16'h0001; u4.DATA_VALID = 1'b1;
    exp_words[0] = 16'h0001; exp_words[1] = 16'hFFFF;
    fork
      begin @(posedge clk); #1; watch(4, 0, 2); end
      begin
        @(posedge clk); #1;
        check("b2b_e_ready", u4.DATA_READY, 1'b0);
        sb.push_back(16'h0001); u4.DATA_IN = 16'hFFFF;
        @(posedge clk); #1;
        check("b2b_e1_ready", u4.DATA_READY, 1'b1);
        @(posedge clk); #1;
        check("b2b_accept2", u4.DATA_READY, 1'b0);
        sb.push_back(16'hFFFF); u4.DATA_VALID = 1'b0;
        cnt = 0;
        repeat (78) begin @(posedge clk); #1; if (u4.DATA_READY) cnt++; end
        check("b2b_stall_ready_cycles", cnt, 0);
        @(posedge clk); #1;
        check("b2b_release", u4.DATA_READY, 1'b1);
      end
    join

    // Table-driven stream with backpressure on the third and fourth words
    for (int i = 0; i < 4; i++) exp_words[i] = {tbl[i].exp_hi, tbl[i].exp_lo};
    @(negedge clk); u4.DATA_IN = tbl[0].din; u4.DATA_VALID = 1'b1;
    fork
      begin @(posedge clk); #1; watch(4, 0, 4); end
      begin
        for (int i = 0; i < 4; i++) begin
          int   waits;
          bit   acc;
          logic r;
          waits = 0;
          acc   = 1'b0;
          if (i > 0) u4.DATA_IN = tbl[i].din;
          while (!acc && waits < 500) begin
            r = u4.DATA_READY;
            @(posedge clk); #1;
            if (r) acc = 1'b1; else waits++;
          end
          check("accept_wait", waits, tbl[i].exp_wait);
          sb.push_back({tbl[i].exp_hi, tbl[i].exp_lo});
        end
        u4.DATA_VALID = 1'b0;
      end
    join

    // Reset during bit 3 of the high byte with a word waiting in hold
    @(negedge clk); u4.DATA_IN = 16'h42EF; u4.DATA_VALID = 1'b1;
    @(posedge clk); #1;
    sb.push_back(16'h42EF); u4.DATA_IN = 16'h1357;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_test_hold_full", u4.DATA_READY, 1'b0);
    sb.push_back(16'h1357); u4.DATA_VALID = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    check("pre_rst_txd_bit3", u4.TXD, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_txd", u4.TXD, 1'b1);
    check("midrst_ready", u4.DATA_READY, 1'b1);
    check("midrst_busy", u4.BUSY, 1'b0);
    check("midrst_done", u4.TX_DONE, 1'b0);
    @(negedge clk); rst = 1'b0; sb.delete();
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (!u4.TXD || u4.BUSY) cnt++; end
    check("held_word_dropped", cnt, 0);
    send_one(16'h6C93, 4, 0);

    // Baud timing at 87 clocks per bit
    send_one(16'h0F33, 87, 1);

    check("sb_drain", sb.size(), 0);
    check("words_received", n_words, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
